// File: rtl/stack_ctrl_if.sv
// ---------------------------------------------------------------------------
// stack_ctrl_if -- requester / completion bundle for stack_ctrl.
//
// Signals
//   req0_valid, req1_valid : requester holds an operation pending
//   req0_op,    req1_op    : 1 = push, 0 = pop
//   req0_data,  req1_data  : push operand (WIDTH bits)
//   gnt[1:0]               : one-hot acceptance pulse (one cycle)
//   rsp_valid              : completion strobe (one cycle)
//   rsp_id                 : requester the completion belongs to
//   rsp_err                : overflow / underflow indication
//   rsp_data               : popped data, zero after a push or an error
//
// Modports
//   master : requester side (drives requests, observes gnt / response)
//   slave  : controller side
// ---------------------------------------------------------------------------
interface stack_ctrl_if #(
    parameter int WIDTH = 6
);
    logic             req0_valid;
    logic             req1_valid;
    logic             req0_op;
    logic             req1_op;
    logic [WIDTH-1:0] req0_data;
    logic [WIDTH-1:0] req1_data;
    logic [1:0]       gnt;
    logic             rsp_valid;
    logic             rsp_id;
    logic             rsp_err;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_data, req1_data,
        input  gnt, rsp_valid, rsp_id, rsp_err, rsp_data
    );

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, req0_data, req1_data,
        output gnt, rsp_valid, rsp_id, rsp_err, rsp_data
    );
endinterface

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl -- two-requester controller for an external LIFO datapath.
//
// One operation is in flight at a time: IDLE samples and arbitrates, EXEC
// issues the push/pop strobe (or flags overflow/underflow), WAIT captures
// popped data, RESP returns the completion.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   bus        : stack_ctrl_if.slave (requests, gnt, completion response)
//   sld_en     : push strobe to the datapath
//   serase     : pop strobe to the datapath
//   stack_in   : push data to the datapath
//   stack_out  : popped data from the datapath (valid in the WAIT cycle)
//   stk_rst    : active-high datapath reset (inverse of rst)
//   count      : number of occupied entries, 0..DEPTH
//   full/empty : count == DEPTH / count == 0
//
// Build option
//   STACK_CTRL_RR_EN : round-robin arbitration between the two requesters;
//                      when undefined req0 has fixed priority.
// ---------------------------------------------------------------------------
module stack_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    stack_ctrl_if.slave      bus,
    output logic             sld_en,
    output logic             serase,
    output logic [WIDTH-1:0] stack_in,
    input  logic [WIDTH-1:0] stack_out,
    output logic             stk_rst,
    output logic [3:0]       count,
    output logic             full,
    output logic             empty
);
    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    state_t           state;
    state_t           state_nxt;
    logic             id_q;
    logic             op_q;
    logic [WIDTH-1:0] data_q;
    logic             any_req;
    logic             win_id;
    logic             op_ok;
    logic [1:0]       gnt_c;
    logic             rsp_valid_c;
    logic             rsp_id_q;
    logic             rsp_err_q;
    logic [WIDTH-1:0] rsp_data_q;

    assign any_req = bus.req0_valid | bus.req1_valid;
    assign op_ok   = op_q ? (count != DEPTH_C) : (count != 4'd0);

`ifdef STACK_CTRL_RR_EN
    // Id of the requester granted last; reset to 1 so req0 wins the first contest.
    logic last_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_id <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_id <= win_id;
        end
    end

    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            win_id = ~last_id;
        end else begin
            win_id = ~bus.req0_valid;
        end
    end
`else
    always_comb begin
        win_id = ~bus.req0_valid;
    end
`endif

    // Strobes, gnt and rsp_valid decode from state only, so the asynchronous
    // reset of the state register drops them immediately.
    always_comb begin
        state_nxt   = state;
        gnt_c       = 2'b00;
        sld_en      = 1'b0;
        serase      = 1'b0;
        stack_in    = '0;
        rsp_valid_c = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                gnt_c = id_q ? 2'b10 : 2'b01;
                if (op_ok && op_q) begin
                    sld_en    = 1'b1;
                    stack_in  = data_q;
                    state_nxt = RESP;
                end else if (op_ok) begin
                    serase    = 1'b1;
                    state_nxt = WAIT;
                end else begin
                    state_nxt = RESP;
                end
            end
            WAIT: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= 4'd0;
            id_q       <= 1'b0;
            op_q       <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                id_q <= win_id;
                op_q <= win_id ? bus.req1_op : bus.req0_op;
            end
            if (sld_en) begin
                count <= count + 4'd1;
            end else if (serase) begin
                count <= count - 4'd1;
            end
            if (state == EXEC) begin
                rsp_id_q   <= id_q;
                rsp_err_q  <= ~op_ok;
                rsp_data_q <= '0;
            end
            if (state == WAIT) begin
                rsp_data_q <= stack_out;
            end
        end
    end

    // Push operand only matters in EXEC, which always follows a capture.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) begin
            data_q <= win_id ? bus.req1_data : bus.req0_data;
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;

    assign stk_rst = ~rst;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == 4'd0);
endmodule

// File: tb/tb_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_ctrl -- scoreboard bench for stack_ctrl.
// Expected completions are queued when a request is driven and compared by a
// negedge monitor when gnt / rsp_valid appear. A small behavioural LIFO plays
// the stack datapath.
// ---------------------------------------------------------------------------
module tb_stack_ctrl;
    localparam int DEPTH = 8;
    localparam int WIDTH = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stack_ctrl_if #(.WIDTH(WIDTH)) bus ();

    logic             sld_en;
    logic             serase;
    logic             stk_rst;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] stack_in;
    logic [WIDTH-1:0] stack_out;
    logic [3:0]       count;

    stack_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sld_en    (sld_en),
        .serase    (serase),
        .stack_in  (stack_in),
        .stack_out (stack_out),
        .stk_rst   (stk_rst),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Behavioural stack datapath
    logic [WIDTH-1:0] mem [DEPTH];
    int               sp;

    always @(posedge clk or posedge stk_rst) begin
        if (stk_rst) begin
            sp        <= 0;
            stack_out <= '0;
        end else if (sld_en && sp < DEPTH) begin
            mem[sp] <= stack_in;
            sp      <= sp + 1;
        end else if (serase && sp > 0) begin
            stack_out <= mem[sp-1];
            sp        <= sp - 1;
        end
    end

    // Scoreboard
    typedef struct {
        logic             id;
        logic             op;
        logic [WIDTH-1:0] pdata;
        logic             err;
        logic [WIDTH-1:0] rdata;
        int               lat;
        int               cnt;
        bit               b2b;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] mdl_stk[$];
    int               mdl_cnt = 0;
    int               n_vec   = 0;
    int               n_bad   = 0;
    int               cyc     = 0;
    int               gnt_cyc = 0;
    int               rsp_cyc = 0;
    exp_t             me;
    logic [1:0]       eg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_op(input logic id, input logic op, input logic [WIDTH-1:0] d, input bit b2b);
        exp_t e;
        e.id    = id;
        e.op    = op;
        e.pdata = d;
        e.b2b   = b2b;
        e.rdata = '0;
        if (op) begin
            e.err = (mdl_cnt == DEPTH);
            if (!e.err) begin
                mdl_stk.push_back(d);
                mdl_cnt++;
            end
            e.lat = 2;
        end else begin
            e.err = (mdl_cnt == 0);
            if (!e.err) begin
                e.rdata = mdl_stk.pop_back();
                mdl_cnt--;
            end
            e.lat = e.err ? 2 : 3;
        end
        e.cnt = mdl_cnt;
        sb.push_back(e);
    endtask

    task automatic drive(input logic id, input logic op, input logic [WIDTH-1:0] d);
        if (id) begin
            bus.req1_valid = 1'b1;
            bus.req1_op    = op;
            bus.req1_data  = d;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_op    = op;
            bus.req0_data  = d;
        end
    endtask

    task automatic release_req(input logic id);
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    task automatic wait_gnt(input logic id);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.gnt[id]) seen = 1'b1;
        end
        check("gnt_timeout", {31'b0, seen}, 32'd1);
        if (!seen) sb.delete();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("rsp_timeout", sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic run_op(input logic id, input logic op, input logic [WIDTH-1:0] d);
        expect_op(id, op, d, 1'b0);
        drive(id, op, d);
        wait_gnt(id);
        release_req(id);
        wait_done();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            check("strobe_excl", {31'b0, sld_en & serase}, 32'd0);
            if (bus.gnt != 2'b00) begin
                if (sb.size() == 0) begin
                    check("gnt_unexpected", {30'b0, bus.gnt}, 32'd0);
                end else begin
                    me = sb[0];
                    eg = me.id ? 2'b10 : 2'b01;
                    check("gnt", {30'b0, bus.gnt}, {30'b0, eg});
                    check("sld_en", {31'b0, sld_en}, {31'b0, me.op & ~me.err});
                    check("serase", {31'b0, serase}, {31'b0, ~me.op & ~me.err});
                    check("stack_in", 32'(stack_in), (me.op && !me.err) ? 32'(me.pdata) : 32'd0);
                    if (me.b2b) check("b2b_gap", cyc - rsp_cyc, 32'd2);
                    gnt_cyc = cyc;
                end
            end else begin
                check("strobe_idle", {30'b0, sld_en, serase}, 32'd0);
            end
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", {31'b0, bus.rsp_valid}, 32'd0);
                end else begin
                    me = sb.pop_front();
                    check("rsp_id", {31'b0, bus.rsp_id}, {31'b0, me.id});
                    check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, me.err});
                    check("rsp_data", 32'(bus.rsp_data), 32'(me.rdata));
                    check("latency", cyc - gnt_cyc + 1, me.lat);
                    check("count", {28'b0, count}, me.cnt);
                    check("full", {31'b0, full}, {31'b0, me.cnt == DEPTH});
                    check("empty", {31'b0, empty}, {31'b0, me.cnt == 0});
                end
                rsp_cyc = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] order;
        bit         last;
        bit         rr;
        bit         w;

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_op    = 1'b0;
        bus.req1_op    = 1'b0;
        bus.req0_data  = '0;
        bus.req1_data  = '0;

        // Reset state
        #12;
        check("rst_count", {28'b0, count}, 32'd0);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_gnt", {30'b0, bus.gnt}, 32'd0);
        check("rst_rsp", {29'b0, bus.rsp_valid, bus.rsp_id, bus.rsp_err}, 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_strobes", {30'b0, sld_en, serase}, 32'd0);
        check("rst_stack_in", 32'(stack_in), 32'd0);
        check("rst_stk_rst", {31'b0, stk_rst}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("stk_rst_rel", {31'b0, stk_rst}, 32'd0);

        // Single push from req0
        run_op(1'b0, 1'b1, 6'h2A);
        check("count_first", {28'b0, count}, 32'd1);

        // Contest: both requesters hold pushes for four operations
`ifdef STACK_CTRL_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w        = rr ? ~last : 1'b0;
            last     = w;
            order[k] = w;
            expect_op(w, 1'b1, w ? 6'h22 : 6'h11, k > 0);
        end
        drive(1'b0, 1'b1, 6'h11);
        drive(1'b1, 1'b1, 6'h22);
        for (int k = 0; k < 4; k++) wait_gnt(order[k]);
        release_req(1'b0);
        release_req(1'b1);
        wait_done();
        check("count_contest", {28'b0, count}, 32'd5);

        // Drain with alternating requesters
        for (int k = 0; k < 5; k++) run_op(k[0], 1'b0, '0);
        check("empty_drained", {31'b0, empty}, 32'd1);

        // Underflow, then push/pop round trip
        run_op(1'b0, 1'b0, '0);
        check("count_underflow", {28'b0, count}, 32'd0);
        run_op(1'b1, 1'b1, 6'h15);
        run_op(1'b0, 1'b0, '0);
        check("empty_roundtrip", {31'b0, empty}, 32'd1);

        // Fill, then overflow
        for (int k = 1; k <= DEPTH; k++) run_op(k[0], 1'b1, 6'(k));
        check("full_filled", {31'b0, full}, 32'd1);
        run_op(1'b0, 1'b1, 6'h3F);
        check("count_overflow", {28'b0, count}, 32'd8);

        // Reset in the WAIT cycle of a pop
        expect_op(1'b1, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, '0);
        wait_gnt(1'b1);
        release_req(1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("abort_strobes", {30'b0, sld_en, serase}, 32'd0);
        check("abort_count", {28'b0, count}, 32'd0);
        check("abort_flags", {30'b0, full, empty}, 32'd1);
        check("abort_gnt", {30'b0, bus.gnt}, 32'd0);
        check("abort_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("abort_stk_rst", {31'b0, stk_rst}, 32'd1);
        sb.delete();
        mdl_stk.delete();
        mdl_cnt = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_count", {28'b0, count}, 32'd0);

        // Operation after reset release
        run_op(1'b1, 1'b1, 6'h2A);
        check("post_rst_push", {28'b0, count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of stack entries in the controlled datapath.
REQ-002 The block SHALL have parameter WIDTH, default 6, meaning the stack data width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Ports req0_valid / req1_valid, input, 1 bit each: the requester holds its operation pending.
REQ-006 Ports req0_op / req1_op, input, 1 bit each: 1 = push, 0 = pop.
REQ-007 Ports req0_data / req1_data, input, WIDTH each: the push operand.
REQ-008 Port gnt, output, 2 bits: one-hot, high for the single cycle in which a request is accepted.
REQ-009 Ports rsp_valid (output, 1), rsp_id (output, 1), rsp_err (output, 1) and rsp_data (output, WIDTH) SHALL form the completion response.
REQ-010 Stack-side ports:
- sld_en, output, 1: push strobe.
- serase, output, 1: pop strobe.
- stack_in, output, WIDTH: push data.
- stack_out, input, WIDTH: popped data.
- stk_rst, output, 1: active-high datapath reset.
REQ-011 Status ports: count (output, 4 bits), full (output, 1), empty (output, 1).

Function
REQ-012 The FSM states SHALL be IDLE, EXEC, WAIT and RESP, with one operation in flight at a time.
REQ-013 In IDLE, when any req*_valid is high at a rising edge, the FSM SHALL:
- arbitrate;
- latch the winner's id, op and data;
- go to EXEC with gnt[id]=1 for the EXEC cycle only.
REQ-014 Requesters SHALL hold valid, op and data until their gnt pulse; requests made while the FSM is not in IDLE are not sampled.
REQ-015 EXEC push with count<DEPTH SHALL:
- assert sld_en=1 for exactly one cycle;
- drive stack_in with the latched data;
- increment count at that edge;
- go to RESP.
REQ-016 EXEC pop with count>0 SHALL:
- assert serase=1 for exactly one cycle;
- decrement count at that edge;
- go to WAIT.
REQ-017 In WAIT, the block SHALL capture stack_out into rsp_data at the rising edge and go to RESP.
REQ-018 EXEC push with count==DEPTH, or pop with count==0, SHALL assert neither strobe, leave count unchanged, set rsp_err=1 and rsp_data=0, and go to RESP.
REQ-019 In RESP, the block SHALL assert rsp_valid=1 for one cycle with rsp_id equal to the latched id, then return to IDLE.
REQ-020 rsp_err SHALL be 0 for successful operations; rsp_data SHALL be 0 after a successful push.
REQ-021 Latency from the IDLE sampling edge to rsp_valid SHALL be:
- push or error: 2 cycles (EXEC, RESP);
- pop: 3 cycles (EXEC, WAIT, RESP).
REQ-022 Throughput SHALL be back-to-back: an IDLE cycle directly follows each RESP cycle, giving one operation per 3 or 4 cycles.
REQ-023 Status outputs SHALL be:
- full = (count==DEPTH) and empty = (count==0), both combinational from count;
- count never wraps, range 0..DEPTH.
REQ-024 sld_en and serase SHALL never be high in the same cycle, and neither SHALL be high outside EXEC.
REQ-025 stk_rst SHALL equal the inverse of rst.

Reset
REQ-026 While rst==0, the block SHALL asynchronously force:
- state=IDLE;
- count=0, full=0, empty=1;
- gnt=0;
- rsp_valid=0, rsp_id=0, rsp_err=0, rsp_data=0;
- sld_en=0, serase=0, stack_in=0;
- round-robin pointer set so that req0 wins the first contest.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no response issued; the strobes drop immediately.
REQ-028 After rst deasserts, the first rising edge SHALL be treated as an IDLE sampling edge.

Configuration
REQ-029 With STACK_CTRL_RR_EN defined, arbitration SHALL be round-robin:
- on a contest, the requester not granted last wins;
- the pointer updates only on a grant.
REQ-030 Without STACK_CTRL_RR_EN, arbitration SHALL be fixed priority, with req0 always winning a contest.

Verification
REQ-031 Reset, then req0 push 6'h2A -> gnt=01 for one cycle, sld_en=1 with stack_in=6'h2A, rsp_valid two cycles after sampling with rsp_id=0, rsp_err=0, and count=1.
REQ-032 Push 6'h01..6'h08 then a ninth push 6'h3F -> count=8 and full=1; the ninth push gives rsp_err=1, no sld_en, and count stays 8.
REQ-033 Pop when empty after reset -> rsp_err=1, rsp_data=0, serase never high, count=0; then push 6'h15 and pop -> rsp_data=6'h15 three cycles after sampling, and empty=1.
REQ-034 With STACK_CTRL_RR_EN, req0 and req1 both valid for 4 operations -> grant order 0,1,0,1; without the macro -> 0,0,0,0.
REQ-035 Assert rst during WAIT of a pop -> no rsp_valid is issued, all outputs are at reset values immediately, and count=0 after release.
